// File: rtl/updown_counter_pkg.sv
// Shared encodings for the up/down counter: boundary modes and FSM states.
package updown_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and boundary detection for one enabled step.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary
);

  always_comb begin
    boundary   = en & (up_dn ? (count >= max_val) : (count == '0));
    next_count = count;
    if (en) begin
      if (!boundary) begin
        next_count = up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
      end else if (mode == MODE_SAT || mode == MODE_ONESHOT) begin
        // Holding also pulls an out-of-range count back to the new limit.
        next_count = (count > max_val) ? max_val : count;
      end else begin
        // Wrap; the reserved mode encoding lands here too.
        next_count = up_dn ? '0 : max_val;
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with programmable limit, load, and wrap/saturate/one-shot modes.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             at_zero,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] RstCount = WIDTH'(RESET_VAL);

  state_e           state_q;
  logic             run_en;
  logic             boundary;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;

  // Once finished, a one-shot ignores en until load or reset.
  assign run_en       = en & (state_q == ST_RUN);
  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  updown_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count      (count),
    .max_val    (max_val),
    .en         (run_en),
    .up_dn      (up_dn),
    .mode       (mode),
    .next_count (next_count),
    .boundary   (boundary)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      count   <= RstCount;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      state_q <= ST_RUN;
      count   <= load_clamped;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      count <= next_count;
      tc    <= boundary;
      if (boundary && mode == MODE_ONESHOT) begin
        state_q <= ST_DONE;
        done    <= 1'b1;
      end
    end
  end

  assign at_zero = (count == '0);
  assign at_max  = (count >= max_val);

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed scenarios plus randomized run vs a model.
module tb_updown_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] max_val;
  logic [W-1:0] count;
  logic         tc;
  logic         done;
  logic         at_zero;
  logic         at_max;

  int total;
  int bad;

  // Reference model state
  int m_count;
  bit m_tc;
  bit m_done;

  updown_counter #(
    .WIDTH     (W),
    .RESET_VAL (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .count    (count),
    .tc       (tc),
    .done     (done),
    .at_zero  (at_zero),
    .at_max   (at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    int mx;
    bit bnd;
    mx = int'(max_val);
    if (load) begin
      m_count = (int'(load_val) < mx) ? int'(load_val) : mx;
      m_tc    = 0;
      m_done  = 0;
    end else if (en && !m_done) begin
      bnd = up_dn ? (m_count >= mx) : (m_count == 0);
      m_tc = bnd;
      if (!bnd) begin
        m_count = up_dn ? m_count + 1 : m_count - 1;
      end else if (mode == 2'd1 || mode == 2'd2) begin
        if (m_count > mx) m_count = mx;
        if (mode == 2'd2) m_done = 1;
      end else begin
        m_count = up_dn ? 0 : mx;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // Advance the model with the inputs present before the edge, then sample after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    m_count = 0;
    m_tc    = 0;
    m_done  = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic do_load(input int val, input int mx);
    load     = 1'b1;
    load_val = W'(val);
    max_val  = W'(mx);
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    en = 0; up_dn = 1; mode = 2'd0; load = 0; load_val = '0; max_val = 4'd9;
    apply_reset();
    total++;
    if (count !== 4'd0 || tc !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%0d tc=%0b done=%0b, want 0/0/0", count, tc, done);
    end
    total++;
    if (at_zero !== 1'b1 || at_max !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: at_zero=%0b at_max=%0b, want 1/0", at_zero, at_max);
    end
  endtask

  task automatic test_wrap_up();
    max_val = 4'd9; mode = 2'd0; up_dn = 1; en = 1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      total++;
      if (count !== W'(k % 10) || tc !== (k % 10 == 0)) begin
        bad++;
        $display("FAIL wrap_up step %0d: count=%0d tc=%0b, want %0d/%0b",
                 k, count, tc, k % 10, (k % 10 == 0));
      end
    end
  endtask

  task automatic test_wrap_down();
    int exp_c[4] = '{1, 0, 9, 8};
    bit exp_t[4] = '{0, 0, 1, 0};
    en = 0; mode = 2'd0;
    do_load(2, 9);
    total++;
    if (count !== 4'd2) begin
      bad++;
      $display("FAIL wrap_down_load: count=%0d, want 2", count);
    end
    up_dn = 0; en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (count !== W'(exp_c[k]) || tc !== exp_t[k]) begin
        bad++;
        $display("FAIL wrap_down step %0d: count=%0d tc=%0b, want %0d/%0b",
                 k, count, tc, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_saturate();
    en = 0; up_dn = 1; mode = 2'd1;
    do_load(0, 5);
    en = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++;
      if (count !== W'((k < 5) ? k : 5) || tc !== (k > 5)) begin
        bad++;
        $display("FAIL saturate step %0d: count=%0d tc=%0b, want %0d/%0b",
                 k, count, tc, (k < 5) ? k : 5, (k > 5));
      end
    end
    en = 0;
    tick();
    total++;
    if (count !== 4'd5 || tc !== 1'b0) begin
      bad++;
      $display("FAIL saturate_en_off: count=%0d tc=%0b, want 5/0", count, tc);
    end
  endtask

  task automatic test_oneshot_load();
    en = 0; up_dn = 1; mode = 2'd2;
    do_load(0, 3);
    en = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (count !== W'(k) || tc !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL oneshot_run %0d: count=%0d tc=%0b done=%0b, want %0d/0/0",
                 k, count, tc, done, k);
      end
    end
    tick();
    total++;
    if (count !== 4'd3 || tc !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_hit: count=%0d tc=%0b done=%0b, want 3/1/1", count, tc, done);
    end
    // en stays high, direction flips and mode leaves one-shot: DONE must hold.
    up_dn = 0; mode = 2'd0;
    tick();
    tick();
    total++;
    if (count !== 4'd3 || tc !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_hold: count=%0d tc=%0b done=%0b, want 3/0/1", count, tc, done);
    end
    mode = 2'd2;
    do_load(12, 3);
    total++;
    if (count !== 4'd3 || tc !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_load: count=%0d tc=%0b done=%0b, want 3/0/0", count, tc, done);
    end
    tick();
    total++;
    if (count !== 4'd2 || done !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_resume: count=%0d done=%0b, want 2/0", count, done);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'd0; up_dn = 1; en = 0;
    do_load(7, 15);
    en = 1;
    #2;
    rst = 1'b0;
    m_count = 0; m_tc = 0; m_done = 0;
    #1;
    total++;
    if (count !== 4'd0 || tc !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_mid: count=%0d tc=%0b done=%0b, want 0/0/0", count, tc, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    // Drive into DONE, then reset between edges.
    mode = 2'd2; en = 0;
    do_load(1, 1);
    en = 1;
    tick();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_prep: done=%0b, want 1", done);
    end
    #3;
    rst = 1'b0;
    m_count = 0; m_tc = 0; m_done = 0;
    #1;
    total++;
    if (count !== 4'd0 || tc !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_done: count=%0d tc=%0b done=%0b, want 0/0/0", count, tc, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    en = 0;
  endtask

  task automatic test_limit_change();
    int exp_c[5] = '{7, 6, 5, 4, 3};
    // Wrap mode: lowering the limit below count forces a wrap.
    en = 0; up_dn = 1; mode = 2'd0;
    do_load(8, 15);
    max_val = 4'd4; en = 1;
    tick();
    total++;
    if (count !== 4'd0 || tc !== 1'b1) begin
      bad++;
      $display("FAIL limit_wrap: count=%0d tc=%0b, want 0/1", count, tc);
    end
    // Saturate mode: clamps to the new limit.
    en = 0; mode = 2'd1;
    do_load(8, 15);
    max_val = 4'd4; en = 1;
    tick();
    total++;
    if (count !== 4'd4 || tc !== 1'b1) begin
      bad++;
      $display("FAIL limit_sat: count=%0d tc=%0b, want 4/1", count, tc);
    end
    // Counting down passes through values above the limit.
    en = 0; mode = 2'd0;
    do_load(8, 15);
    max_val = 4'd4; up_dn = 0; en = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (count !== W'(exp_c[k]) || tc !== 1'b0) begin
        bad++;
        $display("FAIL limit_down %0d: count=%0d tc=%0b, want %0d/0", k, count, tc, exp_c[k]);
      end
    end
    // max_val = 0: every enabled cycle is a boundary.
    en = 0;
    do_load(5, 0);
    up_dn = 1; en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (count !== 4'd0 || tc !== 1'b1) begin
        bad++;
        $display("FAIL max_zero %0d: count=%0d tc=%0b, want 0/1", k, count, tc);
      end
    end
    en = 0;
  endtask

  task automatic test_random();
    load = 0; en = 0;
    do_load(0, 9);
    for (int k = 0; k < 600; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) max_val = W'($urandom_range(0, 15));
      tick();
      total++;
      if (count !== W'(m_count) || tc !== m_tc || done !== m_done ||
          at_zero !== (m_count == 0) || at_max !== (m_count >= int'(max_val))) begin
        bad++;
        $display("FAIL random %0d: count=%0d tc=%0b done=%0b z=%0b m=%0b, want %0d/%0b/%0b/%0b/%0b",
                 k, count, tc, done, at_zero, at_max, m_count, m_tc, m_done,
                 (m_count == 0), (m_count >= int'(max_val)));
      end
    end
    load = 0; en = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    #2;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_oneshot_load();
    test_async_reset();
    test_limit_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
